frame_filler: RTL and testbench

- Responder for the graphics processor's frame-filler command interface.
- On an accepted FILL request, writes one 24-bit colour to every visible pixel of the selected frame buffer in DRAM.
- Writes go out as 256-bit bursts through the DRAM request controller's address FIFO (af) and write-data FIFO (wdf).
- Holds FF_ready low for the whole fill, so the command processor stalls its command stream.

---
 rtl/frame_filler_pkg.sv | 24 ++
 rtl/frame_filler_if.sv | 31 +++
 rtl/frame_filler_addr_gen.sv | 61 ++++++
 rtl/frame_filler.sv | 116 +++++++++++
 tb/tb_frame_filler.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/frame_filler_pkg.sv
// frame_filler_pkg
//   Shared definitions for the frame-filler command responder:
//   FSM state encoding, DRAM burst geometry and the byte-to-burst
//   address packing used by every engine that talks to the DRAM
//   request controller.
package frame_filler_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT0 = 2'd1,
    S_BEAT1 = 2'd2
  } state_t;

  localparam int BURST_BYTES    = 32;   // one af entry covers 32 bytes
  localparam int BURST_LOG2     = $clog2(BURST_BYTES);
  localparam int BEATS          = 2;    // 128-bit wdf beats per burst
  localparam int PIX_BYTES_LOG2 = 2;    // 4 bytes per pixel (pad + RGB)

  // DRAM controller addresses 8-byte units; upper bits are reserved zero.
  function automatic logic [30:0] dram_addr(input logic [27:0] byte_addr);
    return {6'b0, byte_addr[27:3]};
  endfunction

endpackage

// File: rtl/frame_filler_if.sv
// frame_filler_if
//   Groups the command handshake (FF_*) and the DRAM request
//   controller FIFO ports (af_*, wdf_*).
//   slave  : the frame filler (accepts commands, pushes bursts)
//   master : the environment (command processor + DRAM controller)
interface frame_filler_if;
  logic         FF_valid;
  logic [23:0]  FF_color;
  logic [31:0]  FF_frame;
  logic         FF_ready;
  logic         FF_done;
  logic         af_full;
  logic         wdf_full;
  logic [30:0]  af_addr_din;
  logic         af_wr_en;
  logic [127:0] wdf_din;
  logic [15:0]  wdf_mask_din;
  logic         wdf_wr_en;

  modport slave (
    input  FF_valid, FF_color, FF_frame, af_full, wdf_full,
    output FF_ready, FF_done, af_addr_din, af_wr_en,
           wdf_din, wdf_mask_din, wdf_wr_en
  );

  modport master (
    output FF_valid, FF_color, FF_frame, af_full, wdf_full,
    input  FF_ready, FF_done, af_addr_din, af_wr_en,
           wdf_din, wdf_mask_din, wdf_wr_en
  );
endinterface

// File: rtl/frame_filler_addr_gen.sv
// frame_addr_gen
//   Walks the visible area of a frame one 8-pixel burst at a time.
//   Ports:
//     clk, rst      clock, synchronous active-low reset
//     i_clear       restart at burst (0,0)
//     i_advance     step to the next burst (row-major)
//     i_base        frame base, byte address bits [27:5]
//     o_byte_addr   byte address of the current burst
//     o_last        current burst is the final one of the frame
module frame_addr_gen
  import frame_filler_pkg::*;
#(
  parameter int H_PIXELS        = 800,
  parameter int V_PIXELS        = 600,
  parameter int ROW_STRIDE_LOG2 = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_advance,
  input  logic [22:0] i_base,
  output logic [27:0] o_byte_addr,
  output logic        o_last
);

  localparam int XN = H_PIXELS / 8;
  localparam int XW = $clog2(XN + 1);
  localparam int YW = $clog2(V_PIXELS + 1);
  localparam logic [XW-1:0] X_LAST = XW'(XN - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_PIXELS - 1);

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [27:0]   w_base, w_y_off, w_x_off;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_clear) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_advance) begin
      if (r_x == X_LAST) begin
        r_x <= '0;
        r_y <= r_y + YW'(1);
      end else begin
        r_x <= r_x + XW'(1);
      end
    end
  end

  assign o_last = (r_x == X_LAST) && (r_y == Y_LAST);

  // Row pitch is a power of two, so both offsets are pure shifts.
  assign w_base      = 28'(i_base) << BURST_LOG2;
  assign w_y_off     = 28'(r_y) << (ROW_STRIDE_LOG2 + PIX_BYTES_LOG2);
  assign w_x_off     = 28'(r_x) << BURST_LOG2;
  assign o_byte_addr = w_base + w_y_off + w_x_off;

endmodule

// File: rtl/frame_filler.sv
// frame_filler
//   Fills every visible pixel of a frame buffer with one colour.
//   Each 8-pixel burst is one af push plus two wdf pushes; FF_ready
//   stays low for the whole fill so the command stream stalls.
//   Ports:
//     clk   system clock
//     rst   synchronous active-low reset (aborts a fill in progress)
//     bus   frame_filler_if.slave: FF_* command handshake and
//           af/wdf FIFO push interface
module frame_filler
  import frame_filler_pkg::*;
#(
  parameter int H_PIXELS        = 800,
  parameter int V_PIXELS        = 600,
  parameter int ROW_STRIDE_LOG2 = 10
) (
  input  logic           clk,
  input  logic           rst,
  frame_filler_if.slave  bus
);

  state_t      r_state, w_state_nxt;
  logic [23:0] r_color;
  logic [22:0] r_frame;
  logic        r_done;

  logic        w_ready, w_af_wr, w_wdf_wr;
  logic        w_clear, w_adv, w_done_nxt, w_last;
  logic [27:0] w_byte_addr;
  logic        w_unused_frame;

  // Only bits [27:5] of the frame address select a burst.
  assign w_unused_frame = ^{bus.FF_frame[31:28], bus.FF_frame[4:0]};

  frame_addr_gen #(
    .H_PIXELS        (H_PIXELS),
    .V_PIXELS        (V_PIXELS),
    .ROW_STRIDE_LOG2 (ROW_STRIDE_LOG2)
  ) u_addr (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (w_clear),
    .i_advance   (w_adv),
    .i_base      (r_frame),
    .o_byte_addr (w_byte_addr),
    .o_last      (w_last)
  );

  // Everything is qualified by rst so no push or ready leaks out while
  // reset is held, even before the state register has been cleared.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_af_wr     = 1'b0;
    w_wdf_wr    = 1'b0;
    w_clear     = 1'b0;
    w_adv       = 1'b0;
    w_done_nxt  = 1'b0;
    if (rst) begin
      case (r_state)
        S_IDLE: begin
          w_ready = 1'b1;
          if (bus.FF_valid) begin
            w_clear     = 1'b1;
            w_state_nxt = S_BEAT0;
          end
        end
        S_BEAT0: begin
          // Address and first data beat go together so the two FIFOs
          // never drift apart by more than the second beat.
          w_af_wr  = !bus.af_full && !bus.wdf_full;
          w_wdf_wr = w_af_wr;
          if (w_af_wr) w_state_nxt = S_BEAT1;
        end
        S_BEAT1: begin
          w_wdf_wr = !bus.wdf_full;
          if (w_wdf_wr) begin
            w_adv = 1'b1;
            if (w_last) begin
              w_done_nxt  = 1'b1;
              w_state_nxt = S_IDLE;
            end else begin
              w_state_nxt = S_BEAT0;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_color <= '0;
      r_frame <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      if (w_clear) begin
        r_color <= bus.FF_color;
        r_frame <= bus.FF_frame[27:5];
      end
    end
  end

  assign bus.FF_ready     = w_ready;
  assign bus.FF_done      = r_done;
  assign bus.af_wr_en     = w_af_wr;
  assign bus.wdf_wr_en    = w_wdf_wr;
  assign bus.af_addr_din  = dram_addr(w_byte_addr);
  assign bus.wdf_din      = {4{8'h00, r_color}};
  assign bus.wdf_mask_din = 16'h0000;

endmodule

// File: tb/tb_frame_filler.sv
// tb_frame_filler
//   Randomized scoreboard bench for frame_filler on a reduced frame
//   (32x6 pixels, 1024-pixel pitch). Expected bursts are generated from
//   pixel arithmetic when a fill is accepted; a negedge monitor pops and
//   compares every af/wdf push.
module tb_frame_filler;

  localparam int H  = 32;
  localparam int V  = 6;
  localparam int RS = 10;
  localparam int NB = (H / 8) * V;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  frame_filler_if bus();

  logic force_af = 1'b0;
  logic rnd_af   = 1'b0;
  logic rnd_wdf  = 1'b0;
  logic rand_en  = 1'b0;
  assign bus.af_full  = force_af | rnd_af;
  assign bus.wdf_full = rnd_wdf;

  frame_filler #(
    .H_PIXELS        (H),
    .V_PIXELS        (V),
    .ROW_STRIDE_LOG2 (RS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0, errors = 0;
  int af_cnt = 0, wdf_cnt = 0, done_cnt = 0;
  int af0, wdf0, d0, log0, wlog0;
  logic [30:0]  exp_af[$];
  logic [143:0] exp_wd[$];
  logic [30:0]  a_log[$];
  logic [127:0] w_log[$];
  logic [30:0]  held;
  logic [31:0]  f4;
  logic [23:0]  c2;

  task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference: each burst covers 8 pixels of 4 bytes; rows are 2^RS pixels apart.
  task automatic push_model(input logic [23:0] c, input logic [31:0] f);
    int unsigned base, b;
    base = f & 32'h0FFF_FFE0;
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H / 8; x++) begin
        b = base + y * (4 << RS) + x * 8 * 4;
        exp_af.push_back(31'(b / 8));
        exp_wd.push_back({16'h0000, 8'h00, c, 8'h00, c, 8'h00, c, 8'h00, c});
        exp_wd.push_back({16'h0000, 8'h00, c, 8'h00, c, 8'h00, c, 8'h00, c});
      end
  endtask

  // FIFO-full noise
  initial forever begin
    @(posedge clk); #1;
    rnd_af  = rand_en && ($urandom_range(3) == 0);
    rnd_wdf = rand_en && ($urandom_range(2) == 0);
  end

  // Monitor / scoreboard
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("rst_no_af", 144'(bus.af_wr_en), 144'(0));
      chk("rst_no_wdf", 144'(bus.wdf_wr_en), 144'(0));
    end else begin
      if (bus.af_wr_en) begin
        af_cnt++;
        a_log.push_back(bus.af_addr_din);
        if (exp_af.size() == 0) begin
          checks++; errors++;
          $display("FAIL af_unexpected got %0h want none", bus.af_addr_din);
        end else chk("af_addr", 144'(bus.af_addr_din), 144'(exp_af.pop_front()));
      end
      if (bus.wdf_wr_en) begin
        wdf_cnt++;
        w_log.push_back(bus.wdf_din);
        if (exp_wd.size() == 0) begin
          checks++; errors++;
          $display("FAIL wdf_unexpected got %0h want none", bus.wdf_din);
        end else chk("wdf_data", {bus.wdf_mask_din, bus.wdf_din}, exp_wd.pop_front());
      end
      if (bus.FF_done) begin
        done_cnt++;
        chk("done_af_drained", 144'(exp_af.size()), 144'(0));
        chk("done_wdf_drained", 144'(exp_wd.size()), 144'(0));
      end
    end
  end

  task automatic start_fill(input logic [23:0] c, input logic [31:0] f);
    int n = 0;
    @(posedge clk); #1;
    bus.FF_valid = 1'b1;
    bus.FF_color = c;
    bus.FF_frame = f;
    @(negedge clk);
    while (!bus.FF_ready && n < 100) begin @(negedge clk); n++; end
    chk("accept_ready", 144'(bus.FF_ready), 144'(1));
    @(posedge clk); #1;
    bus.FF_valid = 1'b0;
    bus.FF_color = 24'($urandom);
    bus.FF_frame = $urandom;
    af0 = af_cnt; wdf0 = wdf_cnt; d0 = done_cnt;
    log0 = a_log.size(); wlog0 = w_log.size();
    push_model(c, f);
  endtask

  task automatic wait_done(input bit intrude);
    int  n = 0;
    bit  seen = 1'b0;
    while (!seen && n < 2000) begin
      @(negedge clk); n++;
      if (intrude && n >= 10 && n <= 12) begin
        bus.FF_valid = 1'b1;
        bus.FF_color = 24'h00FF00;
        bus.FF_frame = 32'h2000_0000;
        chk("busy_ready_low", 144'(bus.FF_ready), 144'(0));
      end else bus.FF_valid = 1'b0;
      if (bus.FF_done) seen = 1'b1;
    end
    chk("done_seen", 144'(seen), 144'(1));
    if (seen) chk("ready_with_done", 144'(bus.FF_ready), 144'(1));
    repeat (3) @(negedge clk);
    chk("done_once", 144'(done_cnt - d0), 144'(1));
    chk("af_count", 144'(af_cnt - af0), 144'(NB));
    chk("wdf_count", 144'(wdf_cnt - wdf0), 144'(2 * NB));
    chk("idle_ready", 144'(bus.FF_ready), 144'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.FF_valid = 1'b0;
    bus.FF_color = '0;
    bus.FF_frame = '0;

    // Reset
    repeat (3) begin
      @(negedge clk);
      chk("rst_ready_low", 144'(bus.FF_ready), 144'(0));
      chk("rst_done_low", 144'(bus.FF_done), 144'(0));
    end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 144'(bus.FF_ready), 144'(1));
    chk("post_rst_done", 144'(bus.FF_done), 144'(0));

    // Fill 1: red, FIFOs always free, known addresses
    start_fill(24'hFF0000, 32'h1040_0000);
    wait_done(1'b0);
    chk("first_addr", 144'(a_log[log0]), 144'(31'h0008_0000));
    chk("second_addr", 144'(a_log[log0 + 1]), 144'(31'h0008_0004));
    chk("row1_addr", 144'(a_log[log0 + H / 8]), 144'(31'h0008_0200));
    chk("first_data", 144'(w_log[wlog0]), 144'(128'h00FF0000_00FF0000_00FF0000_00FF0000));

    // Fill 2: random colour/frame, random FIFO stalls, intruding request
    rand_en = 1'b1;
    c2 = 24'($urandom);
    start_fill(c2, $urandom);
    wait_done(1'b1);

    // Fill 3: hold af_full in BEAT0 for 5 cycles
    rand_en = 1'b0;
    repeat (2) @(posedge clk);
    start_fill(24'($urandom), $urandom);
    n = 0;
    @(negedge clk);
    while (!bus.af_wr_en && n < 50) begin @(negedge clk); n++; end
    chk("hold_reach", 144'(bus.af_wr_en), 144'(1));
    @(posedge clk);
    @(posedge clk); #1 force_af = 1'b1;
    @(negedge clk);
    held = bus.af_addr_din;
    chk("hold_addr_model", 144'(held), 144'(exp_af[0]));
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("hold_no_af", 144'(bus.af_wr_en), 144'(0));
      chk("hold_no_wdf", 144'(bus.wdf_wr_en), 144'(0));
      chk("hold_addr_stable", 144'(bus.af_addr_din), 144'(held));
    end
    @(posedge clk); #1 force_af = 1'b0;
    wait_done(1'b0);

    // Fill 4: reset mid-row
    rand_en = 1'b1;
    f4 = $urandom;
    start_fill(24'($urandom), f4);
    n = 0;
    while ((af_cnt - af0) < 6 && n < 500) begin @(negedge clk); n++; end
    chk("mid_reach", 144'((af_cnt - af0) >= 6), 144'(1));
    @(posedge clk); #1 rst = 1'b0;
    exp_af.delete();
    exp_wd.delete();
    repeat (2) begin
      @(negedge clk);
      chk("mid_rst_ready_low", 144'(bus.FF_ready), 144'(0));
    end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_release_ready", 144'(bus.FF_ready), 144'(1));
    chk("rst_release_done", 144'(bus.FF_done), 144'(0));

    // Fill 5: restart on the same frame from its base
    start_fill(24'($urandom), f4);
    wait_done(1'b0);
    chk("restart_base", 144'(a_log[log0]), 144'(31'((f4 & 32'h0FFF_FFE0) >> 3)));

    rand_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
